// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit and its alignment checker.
// Contents: memory Size encodings, FSM state type, default memory address width.
package lsu_pkg;

  // Memory port Size encodings (2'b11 is illegal).
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte range of the data memory is 0 .. 2**DEFAULT_MEM_ADDR_W - 1.
  localparam int unsigned DEFAULT_MEM_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational MIPS address-error check for a byte-addressed memory access.
// Shared by the load/store unit and the instruction-fetch side.
// Ports:
//   addr        in  32  byte address
//   size        in  2   00 byte, 01 halfword, 10 word, 11 illegal
//   write       in  1   1 store, 0 load
//   fault       out 1   misaligned, illegal size or outside the memory range
//   fault_store out 1   fault raised by a store (AdES); 0 with fault means AdEL
module lsu_align_check
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W = DEFAULT_MEM_ADDR_W
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        write,
  output logic        fault,
  output logic        fault_store
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr[0];
      SIZE_WORD: misaligned = |addr[1:0];
      default:   misaligned = 1'b1;  // illegal size is reported as an address error
    endcase
  end

  // Any address bit above the memory width set means the byte is not backed by memory.
  assign out_of_range = (addr >> MEM_ADDR_W) != 32'd0;

  assign fault       = misaligned | out_of_range;
  assign fault_store = fault & write;

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: initiator side of the big-endian data memory port.
// Accepts one request at a time, checks it for address errors, holds the memory
// port enabled for WAIT_CYCLES cycles, registers the read data and returns one
// response per request.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_write/size/signed      access type, size and sign-extension select
//   req_addr/req_wdata         byte address, right-justified store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata                 load result (0 for stores and faults)
//   resp_fault/_store          address error flag, set for AdES / clear for AdEL
//   mem_a/di/size/rw/e/se      memory port outputs
//   mem_do                     memory read data (combinational from memory)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MEM_ADDR_W  = DEFAULT_MEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic                  resp_fault_store,
  output logic [MEM_ADDR_W-1:0] mem_a,
  output logic [31:0]           mem_di,
  output logic [1:0]            mem_size,
  output logic                  mem_rw,
  output logic                  mem_e,
  output logic                  mem_se,
  input  logic [31:0]           mem_do
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

  lsu_state_t state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  fault_q, fault_d;
  logic                  fault_store_q, fault_store_d;

  logic chk_fault;
  logic chk_fault_store;

  lsu_align_check #(
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_align_check (
    .addr        (req_addr),
    .size        (req_size),
    .write       (req_write),
    .fault       (chk_fault),
    .fault_store (chk_fault_store)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    size_d        = size_q;
    signed_d      = signed_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    fault_d       = fault_q;
    fault_store_d = fault_store_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d       = req_write;
          size_d        = req_size;
          signed_d      = req_signed;
          addr_d        = req_addr[MEM_ADDR_W-1:0];
          wdata_d       = req_wdata;
          fault_d       = chk_fault;
          fault_store_d = chk_fault_store;
          rdata_d       = 32'd0;
          if (chk_fault) begin
            // Address errors skip the memory entirely.
            state_d = RESP;
          end else begin
            cnt_d   = CntLoad;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Last enabled cycle: memory data is settled, capture it.
          rdata_d = write_q ? 32'd0 : mem_do;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      size_q        <= SIZE_BYTE;
      signed_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      rdata_q       <= 32'd0;
      fault_q       <= 1'b0;
      fault_store_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      fault_q       <= fault_d;
      fault_store_q <= fault_store_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = (state_q == RESP);
  assign resp_rdata       = rdata_q;
  assign resp_fault       = fault_q;
  assign resp_fault_store = fault_store_q;

  // Enable, write strobe and sign-extend are gated to ACCESS so the memory never
  // sees a stray write; address and data simply hold the latched request.
  assign mem_e    = (state_q == ACCESS);
  assign mem_rw   = mem_e & write_q;
  assign mem_se   = mem_e & signed_q & (size_q != SIZE_WORD);
  assign mem_a    = addr_q;
  assign mem_di   = wdata_q;
  assign mem_size = size_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (WAIT_CYCLES 1 and 3), each
// with its own big-endian byte memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned AW = 9;
  localparam int W0 = 1;
  localparam int W1 = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic        fs;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    reset, req_valid, req_ready, req_write, req_signed;
  logic [1:0]    resp_valid, resp_ready, resp_fault, resp_fault_store;
  logic [1:0]    mem_rw, mem_e, mem_se;
  logic [1:0]    req_size [2];
  logic [1:0]    mem_size [2];
  logic [31:0]   req_addr [2];
  logic [31:0]   req_wdata [2];
  logic [31:0]   resp_rdata [2];
  logic [31:0]   mem_di [2];
  logic [31:0]   mem_do [2];
  logic [AW-1:0] mem_a [2];
  logic [7:0]    mem [2][512];
  logic          preload;

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_checks = 0;
  int   n_errors = 0;

  load_store_unit #(.WAIT_CYCLES(W0), .MEM_ADDR_W(AW)) u_dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
    .resp_fault_store(resp_fault_store[0]), .mem_a(mem_a[0]), .mem_di(mem_di[0]),
    .mem_size(mem_size[0]), .mem_rw(mem_rw[0]), .mem_e(mem_e[0]), .mem_se(mem_se[0]),
    .mem_do(mem_do[0])
  );

  load_store_unit #(.WAIT_CYCLES(W1), .MEM_ADDR_W(AW)) u_dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
    .resp_fault_store(resp_fault_store[1]), .mem_a(mem_a[1]), .mem_di(mem_di[1]),
    .mem_size(mem_size[1]), .mem_rw(mem_rw[1]), .mem_e(mem_e[1]), .mem_se(mem_se[1]),
    .mem_do(mem_do[1])
  );

  // Big-endian read with memory-side sign extension.
  function automatic logic [31:0] rd_model(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [1:0] sz, input logic se);
    case (sz)
      2'b00:   return se ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'b01:   return se ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
      default: return {b0, b1, b2, b3};
    endcase
  endfunction

  assign mem_do[0] = rd_model(mem[0][mem_a[0]], mem[0][mem_a[0] + 9'd1],
                              mem[0][mem_a[0] + 9'd2], mem[0][mem_a[0] + 9'd3],
                              mem_size[0], mem_se[0]);
  assign mem_do[1] = rd_model(mem[1][mem_a[1]], mem[1][mem_a[1] + 9'd1],
                              mem[1][mem_a[1] + 9'd2], mem[1][mem_a[1] + 9'd3],
                              mem_size[1], mem_se[1]);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (preload) begin
        for (int j = 0; j < 512; j++) mem[i][j] <= 8'h00;
        mem[i][0] <= 8'h84; mem[i][1] <= 8'h21; mem[i][2] <= 8'h7F; mem[i][3] <= 8'h10;
        mem[i][7] <= 8'h2A;
      end else if (mem_e[i] && mem_rw[i]) begin
        case (mem_size[i])
          2'b00: mem[i][mem_a[i]] <= mem_di[i][7:0];
          2'b01: begin
            mem[i][mem_a[i]]        <= mem_di[i][15:8];
            mem[i][mem_a[i] + 9'd1] <= mem_di[i][7:0];
          end
          default: begin
            mem[i][mem_a[i]]        <= mem_di[i][31:24];
            mem[i][mem_a[i] + 9'd1] <= mem_di[i][23:16];
            mem[i][mem_a[i] + 9'd2] <= mem_di[i][15:8];
            mem[i][mem_a[i] + 9'd3] <= mem_di[i][7:0];
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    exp_t e;
    int   depth;
    for (int i = 0; i < 2; i++) begin
      if (resp_valid[i] && resp_ready[i] && !reset[i]) begin
        depth = (i == 0) ? sb0.size() : sb1.size();
        if (depth == 0) begin
          check($sformatf("unexpected_resp_dut%0d", i), {31'd0, resp_valid[i]}, 32'd0);
        end else begin
          e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
          check({e.tag, "_rdata"}, resp_rdata[i], e.rdata);
          check({e.tag, "_fault"}, {30'd0, resp_fault[i], resp_fault_store[i]},
                {30'd0, e.fault, e.fs});
        end
      end
    end
  end

  task automatic do_req(input int i, input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ef, input int hold);
    int   wc, lat, e_cyc, rw_cyc, n;
    bit   port_ok;
    exp_t x;
    wc = (i == 0) ? W0 : W1;
    @(posedge clk); #1;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_req_ready"}, {31'd0, req_ready[i]}, 32'd1);
    x.rdata = er; x.fault = ef; x.fs = ef & w; x.tag = tag;
    if (i == 0) sb0.push_back(x);
    else sb1.push_back(x);
    resp_ready[i] = (hold == 0);
    req_valid[i] = 1'b1; req_write[i] = w; req_size[i] = sz; req_signed[i] = sg;
    req_addr[i] = a; req_wdata[i] = wd;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 0; e_cyc = 0; rw_cyc = 0; port_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resp_valid[i]) begin
        lat = k;
        break;
      end
      if (mem_e[i]) begin
        e_cyc++;
        if (mem_rw[i]) rw_cyc++;
        if (mem_a[i] !== a[AW-1:0] || mem_size[i] !== sz || req_ready[i] !== 1'b0 ||
            (w && mem_di[i] !== wd) || mem_se[i] !== (sg && sz != SIZE_WORD))
          port_ok = 1'b0;
      end
    end
    check({tag, "_latency"}, lat, ef ? 32'd1 : wc + 1);
    check({tag, "_mem_e_cycles"}, e_cyc, ef ? 32'd0 : wc);
    check({tag, "_mem_rw_cycles"}, rw_cyc, (ef || !w) ? 32'd0 : wc);
    if (!ef) check({tag, "_mem_port"}, {31'd0, port_ok}, 32'd1);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({tag, "_hold_flags"}, {30'd0, resp_valid[i], req_ready[i]}, 32'd2);
        check({tag, "_hold_rdata"}, resp_rdata[i], er);
      end
      @(posedge clk); #1;
      resp_ready[i] = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic reset_mid_access();
    int n_valid, n_e;
    @(posedge clk); #1;
    check("rst_pre_ready", {31'd0, req_ready[1]}, 32'd1);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = SIZE_WORD; req_signed[1] = 1'b0;
    req_addr[1] = 32'd0; req_wdata[1] = 32'd0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("rst_in_access", {31'd0, mem_e[1]}, 32'd1);
    reset[1] = 1'b1;
    @(posedge clk); #1;
    reset[1] = 1'b0;
    check("rst_flags", {24'd0, req_ready[1], resp_valid[1], mem_e[1], mem_rw[1], mem_se[1],
          resp_fault[1], resp_fault_store[1], 1'b0}, 32'h80);
    check("rst_rdata", resp_rdata[1], 32'd0);
    check("rst_mem_a", {23'd0, mem_a[1]}, 32'd0);
    check("rst_mem_di_size", mem_di[1] | {30'd0, mem_size[1]}, 32'd0);
    n_valid = 0; n_e = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid[1]) n_valid++;
      if (mem_e[1]) n_e++;
    end
    check("rst_no_resp", n_valid, 32'd0);
    check("rst_no_mem_e", n_e, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 2'b11; preload = 1'b1; req_valid = 2'b00; resp_ready = 2'b11;
    req_write = 2'b00; req_signed = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_size[i] = 2'b00; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_flags_dut%0d", i),
            {25'd0, req_ready[i], resp_valid[i], resp_fault[i], resp_fault_store[i],
             mem_e[i], mem_rw[i], mem_se[i]}, 32'h40);
      check($sformatf("reset_rdata_dut%0d", i), resp_rdata[i], 32'd0);
      check($sformatf("reset_mem_dut%0d", i),
            {23'd0, mem_a[i]} | mem_di[i] | {30'd0, mem_size[i]}, 32'd0);
    end
    preload = 1'b0;
    reset = 2'b00;

    // WAIT_CYCLES = 1
    do_req(0, "lw0",    0, SIZE_WORD, 0, 32'h0,        32'h0,        32'h8421_7F10, 0, 0);
    do_req(0, "lb0s",   0, SIZE_BYTE, 1, 32'h0,        32'h0,        32'hFFFF_FF84, 0, 0);
    do_req(0, "lhu2",   0, SIZE_HALF, 0, 32'h2,        32'h0,        32'h0000_7F10, 0, 0);
    do_req(0, "lh0s",   0, SIZE_HALF, 1, 32'h0,        32'h0,        32'hFFFF_8421, 0, 0);
    do_req(0, "sw8",    1, SIZE_WORD, 0, 32'h8,        32'h0010_0015, 32'h0,        0, 0);
    do_req(0, "lw8",    0, SIZE_WORD, 0, 32'h8,        32'h0,        32'h0010_0015, 0, 0);
    do_req(0, "lbu7",   0, SIZE_BYTE, 0, 32'h7,        32'h0,        32'h0000_002A, 0, 0);
    do_req(0, "lb1s",   0, SIZE_BYTE, 1, 32'h1,        32'h0,        32'h0000_0021, 0, 0);
    do_req(0, "sh4",    1, SIZE_HALF, 0, 32'h4,        32'h0000_BEEF, 32'h0,        0, 0);
    do_req(0, "lw4",    0, SIZE_WORD, 0, 32'h4,        32'h0,        32'hBEEF_002A, 0, 0);
    do_req(0, "sb1ff",  1, SIZE_BYTE, 0, 32'h1FF,      32'h0000_00A5, 32'h0,        0, 0);
    do_req(0, "lb1ffs", 0, SIZE_BYTE, 1, 32'h1FF,      32'h0,        32'hFFFF_FFA5, 0, 0);
    do_req(0, "lh3",    0, SIZE_HALF, 0, 32'h3,        32'h0,        32'h0,         1, 0);
    do_req(0, "sw200",  1, SIZE_WORD, 0, 32'h200,      32'hDEAD_BEEF, 32'h0,        1, 0);
    do_req(0, "lsz3",   0, 2'b11,     0, 32'h0,        32'h0,        32'h0,         1, 0);
    do_req(0, "lw2",    0, SIZE_WORD, 0, 32'h2,        32'h0,        32'h0,         1, 0);
    do_req(0, "lwhi",   0, SIZE_WORD, 0, 32'h8000_0000, 32'h0,       32'h0,         1, 0);
    do_req(0, "lw0b",   0, SIZE_WORD, 0, 32'h0,        32'h0,        32'h8421_7F10, 0, 0);

    // WAIT_CYCLES = 3
    do_req(1, "w3_bp_lb0s", 0, SIZE_BYTE, 1, 32'h0, 32'h0,        32'hFFFF_FF84, 0, 5);
    reset_mid_access();
    do_req(1, "w3_lw0",     0, SIZE_WORD, 0, 32'h0, 32'h0,        32'h8421_7F10, 0, 0);
    do_req(1, "w3_sw10",    1, SIZE_WORD, 0, 32'h10, 32'h1234_5678, 32'h0,       0, 0);
    do_req(1, "w3_lh12s",   0, SIZE_HALF, 1, 32'h12, 32'h0,       32'h0000_5678, 0, 0);
    do_req(1, "w3_sh1",     1, SIZE_HALF, 0, 32'h1, 32'h0,        32'h0,         1, 0);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", sb0.size() + sb1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the byte-addressed, big-endian data memory port (9-bit address, Size 00 byte / 01 halfword / 10 word, R_W 0 read / 1 write, E enable, SE sign-extend). The unit sits in the MEM stage of the MIPS pipeline. It accepts one load/store request at a time over a valid/ready handshake and checks alignment and range. It then drives the memory port for a fixed number of wait cycles, captures read data into a register, and returns one response per request, flagging MIPS address errors (AdEL/AdES) instead of touching memory.

## Interface
- `WAIT_CYCLES`, default 1: cycles `mem_e` is held per access (≥1); read data is sampled on the last one.
- `MEM_ADDR_W`, default 9: memory address width; valid byte range is 0..2^MEM_ADDR_W−1.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `req_write` in 1: 1 store, 0 load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend loaded byte/halfword.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes response.
- `resp_rdata` out 32: load result; 0 for stores and faults.
- `resp_fault` out 1: address error; no memory access performed.
- `resp_fault_store` out 1: fault was on a store (AdES); 0 means AdEL.
- `mem_a` out MEM_ADDR_W: memory address.
- `mem_di` out 32: memory write data.
- `mem_size` out 2: memory Size.
- `mem_rw` out 1: memory R_W.
- `mem_e` out 1: memory enable.
- `mem_se` out 1: memory SE.
- `mem_do` in 32: memory read data (combinational from memory).

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch write/size/signed/addr/wdata and evaluate fault.
  - Fault if `req_size`=11, or halfword with addr[0]≠0, or word with addr[1:0]≠0, or addr[31:MEM_ADDR_W]≠0.
  - On fault: go to RESP with `resp_fault`=1, `resp_fault_store`=`req_write`, `resp_rdata`=0.
  - Otherwise: load the wait counter with WAIT_CYCLES−1 and go to ACCESS.
- ACCESS: `mem_e`=1, and `mem_a`, `mem_di`, `mem_size`, `mem_rw`, `mem_se` come from the latched request, stable for the whole state. The counter decrements each cycle.
  - At count 0 with a load, register `mem_do` into `resp_rdata`. Stores set `resp_rdata` to 0.
  - Go to RESP.
- RESP: `resp_valid`=1; all response outputs are held until `resp_ready`=1, then return to IDLE.
- `req_ready` is 0 in ACCESS and RESP. There is no request queue.
- Outside ACCESS: `mem_e`=0 and `mem_rw`=0, so no spurious writes. The address and data outputs may keep their last values.
- Sign extension is performed by the memory via `mem_se`. The unit does not re-extend. For word accesses `mem_se` is driven 0.

## Timing
- Reset values:
  - State IDLE, so `req_ready`=1.
  - `resp_valid`, `resp_fault`, `resp_fault_store`=0; `resp_rdata`=0.
  - `mem_e`, `mem_rw`, `mem_se`=0; `mem_a`=0, `mem_di`=0, `mem_size`=00.
- Request accepted at edge N:
  - `mem_e` is high in cycles N+1..N+WAIT_CYCLES.
  - `resp_valid` rises at edge N+WAIT_CYCLES+1, with `resp_rdata` valid in the same cycle.
- Fault accepted at edge N: `resp_valid` at N+1, and `mem_e` is never asserted.
- If `resp_ready` is high in the first RESP cycle, the unit is IDLE the next cycle and can accept a new request there. Throughput is one request per WAIT_CYCLES+2 cycles; a fault takes 2 cycles.
- `resp_ready` asserted while `resp_valid`=0 is ignored.
- `reset` in any state:
  - Next edge: IDLE, all outputs at reset values.
  - An in-flight access is abandoned, and no response is ever produced for it.
  - A store aborted mid-ACCESS may already have updated memory; this is acceptable.
- `req_valid` together with `reset` is not accepted.

## Structure
- Package `lsu_pkg`:
  - Size constants `SIZE_BYTE`=2'b00, `SIZE_HALF`=2'b01, `SIZE_WORD`=2'b10.
  - State enum `lsu_state_t` {IDLE, ACCESS, RESP}.
  - Default `MEM_ADDR_W`=9.
- Sub-module `lsu_align_check`: combinational; inputs addr, size, write; outputs fault and fault_store. It is reused later by the instruction-fetch side.
- The top module holds the FSM, wait counter, request latch and response registers.

## Test plan
- Preload mem[0..7]=`84 21 7F 10 00 00 00 2A`, WAIT_CYCLES=1.
  - Word load at 0 → `resp_rdata`=0x8421_7F10, `resp_valid` 2 cycles after accept.
- Same preload:
  - Signed byte load at 0 → 0xFFFF_FF84.
  - Unsigned halfword load at 2 → 0x0000_7F10.
  - Signed halfword load at 0 → 0xFFFF_8421.
- Word store 0x0010_0015 at 8, then word load at 8 → 0x0010_0015. During the store, `mem_e`=1 and `mem_rw`=1 for exactly WAIT_CYCLES cycles.
- Faults:
  - Halfword load at 3 → `resp_fault`=1, `resp_fault_store`=0, `resp_rdata`=0, `mem_e` never high.
  - Word store at 0x200 → `resp_fault`=1, `resp_fault_store`=1.
- Backpressure and reset, with WAIT_CYCLES=3:
  - Hold `resp_ready`=0 for 5 cycles → `resp_valid` and data held stable, `req_ready`=0 throughout.
  - Assert `reset` during ACCESS → next cycle IDLE, `mem_e`=0, no response.
